// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard stall, bubble insertion and a
// saturating stall counter. Define ID_EX_FWD_EN to add the EX forwarding selects.
module id_ex_stage #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_d,
    input  logic [31:0]       pc_d,
    input  logic [31:0]       rd1_d,
    input  logic [31:0]       rd2_d,
    input  logic [31:0]       imm_d,
    input  logic [4:0]        rs1_d,
    input  logic [4:0]        rs2_d,
    input  logic [4:0]        rd_d,
    input  logic              reg_we_d,
    input  logic              mem_re_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic              flush_e,
`ifdef ID_EX_FWD_EN
    input  logic [4:0]        rd_m,
    input  logic [4:0]        rd_w,
    input  logic              reg_we_m,
    input  logic              reg_we_w,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
`endif
    output logic              stall_d,
    output logic              valid_e,
    output logic [31:0]       pc_e,
    output logic [31:0]       rd1_e,
    output logic [31:0]       rd2_e,
    output logic [31:0]       imm_e,
    output logic [4:0]        rs1_e,
    output logic [4:0]        rs2_e,
    output logic [4:0]        rd_e,
    output logic              reg_we_e,
    output logic              mem_re_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       rd1;
        logic [31:0]       rd2;
        logic [31:0]       imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              reg_we;
        logic              mem_re;
        logic [CTRL_W-1:0] ctrl;
    } ex_t;

    ex_t  ex_in;
    ex_t  ex_q;
    logic valid_q;

    // Load in EX feeding a source of the decode instruction; a flush kills it.
    assign stall_d = valid_d & valid_q & ex_q.mem_re & (ex_q.rd != 5'd0) &
                     ((ex_q.rd == rs1_d) | (ex_q.rd == rs2_d)) & ~flush_e;

    always_comb begin
        ex_in        = '0;
        ex_in.pc     = pc_d;
        ex_in.rd1    = rd1_d;
        ex_in.rd2    = rd2_d;
        ex_in.imm    = imm_d;
        ex_in.rs1    = rs1_d;
        ex_in.rs2    = rs2_d;
        ex_in.rd     = rd_d;
        ex_in.reg_we = reg_we_d & valid_d;
        ex_in.mem_re = mem_re_d & valid_d;
        ex_in.ctrl   = ctrl_d;
    end

    // Reset, flush and stall all collapse to the same all-zero NOP.
    always_ff @(posedge clk) begin
        if (rst || flush_e || stall_d) begin
            ex_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            ex_q    <= ex_in;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall_d && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign valid_e  = valid_q;
    assign pc_e     = ex_q.pc;
    assign rd1_e    = ex_q.rd1;
    assign rd2_e    = ex_q.rd2;
    assign imm_e    = ex_q.imm;
    assign rs1_e    = ex_q.rs1;
    assign rs2_e    = ex_q.rs2;
    assign rd_e     = ex_q.rd;
    assign reg_we_e = ex_q.reg_we;
    assign mem_re_e = ex_q.mem_re;
    assign ctrl_e   = ex_q.ctrl;

`ifdef ID_EX_FWD_EN
    // MEM result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic we_m,
                                           input logic [4:0] dst_m, input logic we_w,
                                           input logic [4:0] dst_w);
        if (we_m && dst_m != 5'd0 && dst_m == rs)      return 2'b10;
        else if (we_w && dst_w != 5'd0 && dst_w == rs) return 2'b01;
        else                                           return 2'b00;
    endfunction

    assign fwd_a_e = fwd_sel(ex_q.rs1, reg_we_m, rd_m, reg_we_w, rd_w);
    assign fwd_b_e = fwd_sel(ex_q.rs2, reg_we_m, rd_m, reg_we_w, rd_w);
`endif

endmodule
